// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg -- shared types for the EX/MEM memory bus interface.
//
// Contents:
//   mem_op_e  memory operation encoding presented on mem_op
//   state_e   bus FSM states (IDLE, REQ, ACCESS, STALL)
//   helpers   operation classification (load/store, access width)
//
// Configuration macro used by the files importing this package:
//   MEM_SUBWORD_EN  defined   -> half and byte operations are supported
//                   undefined -> only word operations reach the bus
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [3:0] {
        NOP  = 4'd0,
        LDW  = 4'd1,
        STW  = 4'd2,
        LDH  = 4'd3,
        LDHU = 4'd4,
        LDB  = 4'd5,
        LDBU = 4'd6,
        STH  = 4'd7,
        STB  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } state_e;

    localparam logic [3:0] BE_ALL = 4'b1111;

    function automatic logic is_load(input mem_op_e op);
        return (op == LDW) || (op == LDH) || (op == LDHU) ||
               (op == LDB) || (op == LDBU);
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == STW) || (op == STH) || (op == STB);
    endfunction

    function automatic logic is_word(input mem_op_e op);
        return (op == LDW) || (op == STW);
    endfunction

    function automatic logic is_half(input mem_op_e op);
        return (op == LDH) || (op == LDHU) || (op == STH);
    endfunction

    function automatic logic is_byte(input mem_op_e op);
        return (op == LDB) || (op == LDBU) || (op == STB);
    endfunction

endpackage

// File: rtl/mem_align.sv
// -----------------------------------------------------------------------------
// mem_align -- combinational lane steering and load extension.
//
// Byte order is big-endian: byte offset 0 lives in bits 31:24 and is enabled
// by be[3].
//
// Ports:
//   mem_op    in  4   operation (mem_op_e encoding)
//   offset    in  2   byte offset within the word (ex_out[1:0])
//   wr_data   in  32  raw store data (value in the low bits)
//   rd_data   in  32  raw word read from the bus
//   be        out 4   byte enables for the access
//   wr_lanes  out 32  store data replicated across all lanes
//   rd_ext    out 32  selected lane of rd_data, sign/zero extended
//
// Configuration: with MEM_SUBWORD_EN undefined the lane logic is removed and
// the block passes whole words through with every byte enabled.
// -----------------------------------------------------------------------------
module mem_align
    import mem_pkg::*;
(
    input  logic [3:0]  mem_op,
    input  logic [1:0]  offset,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    output logic [3:0]  be,
    output logic [31:0] wr_lanes,
    output logic [31:0] rd_ext
);

`ifdef MEM_SUBWORD_EN
    mem_op_e     op;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign op = mem_op_e'(mem_op);

    // Lane selection for loads; halves only ever sit at offset 0 or 2.
    always_comb begin
        rd_byte = 8'h00;
        case (offset)
            2'd0:    rd_byte = rd_data[31:24];
            2'd1:    rd_byte = rd_data[23:16];
            2'd2:    rd_byte = rd_data[15:8];
            default: rd_byte = rd_data[7:0];
        endcase
        rd_half = offset[1] ? rd_data[15:0] : rd_data[31:16];
    end

    always_comb begin
        be       = BE_ALL;
        wr_lanes = wr_data;
        rd_ext   = rd_data;
        if (is_byte(op)) begin
            be       = 4'b1000 >> offset;
            wr_lanes = {4{wr_data[7:0]}};
            rd_ext   = (op == LDB) ? {{24{rd_byte[7]}}, rd_byte}
                                   : {24'h000000, rd_byte};
        end else if (is_half(op)) begin
            be       = offset[1] ? 4'b0011 : 4'b1100;
            wr_lanes = {2{wr_data[15:0]}};
            rd_ext   = (op == LDH) ? {{16{rd_half[15]}}, rd_half}
                                   : {16'h0000, rd_half};
        end
    end
`else
    logic unused;

    assign unused   = ^{mem_op, offset};
    assign be       = BE_ALL;
    assign wr_lanes = wr_data;
    assign rd_ext   = rd_data;
`endif

endmodule

// File: rtl/mem_bus_if.sv
// -----------------------------------------------------------------------------
// mem_bus_if -- MEM stage interface between the EX/MEM register and an
// external request/grant/strobe/ready memory bus.
//
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   en, mem_op         EX/MEM entry valid and its memory operation
//   ex_out, wr_data    ALU result (byte address for memory ops), store data
//   stall, flush       pipeline stall and flush
//   out                data toward the MEM register
//   miss_align         misaligned access (combinational)
//   busy               stall request to pipeline control
//   bus_req_/bus_grnt_ bus request / grant, active-low
//   bus_as_            address strobe, active-low, one cycle per access
//   bus_rw             1 = read, 0 = write
//   bus_addr           word address ex_out[31:2]
//   bus_be             byte enables, bit 3 = byte at offset 0
//   bus_wr_data        lane-steered store data
//   bus_rd_data        read data
//   bus_rdy_           access complete, active-low
//
// Bus handshake: bus_req_ is held low from the start of an access until the
// cycle bus_rdy_ is seen low. The bus owns the cycle once bus_grnt_ is seen
// low in REQ; the address phase is then strobed for exactly one cycle with
// bus_as_, and the address/control/data registers stay stable until the next
// grant. The EX/MEM inputs are expected to stay stable while busy is high.
//
// Configuration macro: MEM_SUBWORD_EN (defined enables half/byte accesses;
// undefined makes every half/byte op report miss_align).
// -----------------------------------------------------------------------------
module mem_bus_if
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  mem_op,
    input  logic [31:0] ex_out,
    input  logic [31:0] wr_data,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] out,
    output logic        miss_align,
    output logic        busy,
    output logic        bus_req_,
    input  logic        bus_grnt_,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_
);

    mem_op_e     op;
    state_e      state;
    state_e      state_nxt;
    logic        access;
    logic        start;
    logic [3:0]  al_be;
    logic [31:0] al_wr;
    logic [31:0] al_rd;
    logic [31:0] result_val;
    logic [31:0] result_q;

    assign op = mem_op_e'(mem_op);

    mem_align u_align (
        .mem_op   (mem_op),
        .offset   (ex_out[1:0]),
        .wr_data  (wr_data),
        .rd_data  (bus_rd_data),
        .be       (al_be),
        .wr_lanes (al_wr),
        .rd_ext   (al_rd)
    );

    // Alignment check on the live inputs; a misaligned op never leaves IDLE.
    always_comb begin
        miss_align = 1'b0;
        if (en) begin
            if (is_word(op)) begin
                miss_align = (ex_out[1:0] != 2'b00);
`ifdef MEM_SUBWORD_EN
            end else if (is_half(op)) begin
                miss_align = ex_out[0];
`else
            end else if (is_half(op) || is_byte(op)) begin
                miss_align = 1'b1;
`endif
            end
        end
    end

    assign access = en && (is_load(op) || is_store(op)) && !miss_align;

    // Gating with rst keeps bus_req_ released while reset is held, even if
    // the pipeline is still presenting an access.
    assign start = rst && access && !flush;

    // Stores hand the address through; loads return the extracted lane.
    assign result_val = is_store(op) ? ex_out : al_rd;

    // Next state and Moore/Mealy outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        bus_req_  = 1'b1;
        out       = ex_out;
        case (state)
            IDLE: begin
                if (start) begin
                    busy      = 1'b1;
                    bus_req_  = 1'b0;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                busy     = 1'b1;
                bus_req_ = 1'b0;
                if (!bus_grnt_) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (bus_rdy_) begin
                    busy     = 1'b1;
                    bus_req_ = 1'b0;
                end else begin
                    out       = result_val;
                    state_nxt = stall ? STALL : IDLE;
                end
            end
            STALL: begin
                out = result_q;
                if (!stall) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, address phase registers and the captured result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            bus_as_     <= 1'b1;
            bus_rw      <= 1'b1;
            bus_addr    <= 30'd0;
            bus_be      <= 4'b0000;
            bus_wr_data <= 32'd0;
            result_q    <= 32'd0;
        end else begin
            state   <= state_nxt;
            // Strobe defaults high so it is low for the single grant cycle only.
            bus_as_ <= 1'b1;
            if (state == REQ && !bus_grnt_) begin
                bus_as_     <= 1'b0;
                bus_rw      <= is_load(op);
                bus_addr    <= ex_out[31:2];
                bus_be      <= al_be;
                bus_wr_data <= al_wr;
            end
            if (state == ACCESS && !bus_rdy_) begin
                result_q <= result_val;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_if.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_if -- self-checking bench for mem_bus_if.
// Inputs change on the falling clock edge and outputs are sampled shortly
// after, away from the rising edge. The bus slave reacts to bus_req_ and
// bus_as_ with programmable grant and ready delays.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_bus_if;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  mem_op = 4'd0;
  logic [31:0] ex_out = 32'd0;
  logic [31:0] wr_data = 32'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] out;
  logic        miss_align;
  logic        busy;
  logic        bus_req_;
  logic        bus_grnt_ = 1'b1;
  logic        bus_as_;
  logic        bus_rw;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data = 32'd0;
  logic        bus_rdy_ = 1'b1;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_bus_if dut (
    .clk(clk), .rst(rst), .en(en), .mem_op(mem_op), .ex_out(ex_out),
    .wr_data(wr_data), .stall(stall), .flush(flush), .out(out),
    .miss_align(miss_align), .busy(busy), .bus_req_(bus_req_),
    .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  // ---------------- reference model ----------------
  function automatic bit subword_ok();
`ifdef MEM_SUBWORD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int op_size(input logic [3:0] op);
    case (op)
      LDW, STW:        return 4;
      LDH, LDHU, STH:  return 2;
      LDB, LDBU, STB:  return 1;
      default:         return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [3:0] op);
    return (op == STW) || (op == STH) || (op == STB);
  endfunction

  function automatic bit ref_misalign(input logic [3:0] op, input logic [31:0] addr);
    int sz;
    sz = op_size(op);
    if (sz == 0) return 1'b0;
    if (sz < 4 && !subword_ok()) return 1'b1;
    return (int'(addr[1:0]) % sz) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [3:0] op, input logic [31:0] addr);
    int sz;
    int off;
    logic [3:0] b;
    sz = op_size(op);
    off = int'(addr[1:0]);
    b = 4'b0000;
    if (sz == 4 || !subword_ok()) return 4'b1111;
    for (int k = 0; k < sz; k++) b[3 - (off + k)] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] wd);
    case (op_size(op))
      1:       return {4{wd[7:0]}};
      2:       return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int sz;
    int off;
    logic [63:0] rd64;
    logic [63:0] v;
    sz = op_size(op);
    off = int'(addr[1:0]);
    rd64 = {32'd0, rd};
    v = 64'd0;
    if (op_store(op)) return addr;
    if (sz == 4) return rd;
    for (int k = 0; k < sz; k++) v = (v << 8) | ((rd64 >> (8 * (3 - off - k))) & 64'hFF);
    if ((op == LDB || op == LDH) && v[8 * sz - 1]) v = v | ~((64'd1 << (8 * sz)) - 64'd1);
    return v[31:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic recover();
    @(negedge clk);
    rst = 1'b0; en = 1'b0; stall = 1'b0; flush = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One bus access through the DUT, with expectations supplied by the caller.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int gdel, input int rdel, input int stall_n,
                       input bit flush_mid, input logic [31:0] exp_out, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input string name);
    int cyc = 0;
    int req_low = 0;
    int as_low = 0;
    int acc_cyc = 0;
    int busy_n = 0;
    bit done = 1'b0;
    bit as_seen = 1'b0;
    logic [29:0] cap_addr = 30'd0;
    logic cap_rw = 1'b0;
    logic [3:0] cap_be = 4'd0;
    logic [31:0] cap_wd = 32'd0;
    logic [31:0] exp_v;
    exp_q.push_back(exp_out);
    @(negedge clk);
    en = 1'b1; mem_op = op; ex_out = addr; wr_data = wd; bus_rd_data = rd;
    stall = (stall_n > 0); flush = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    while (!done && cyc < 40) begin
      if (cyc > 0) @(negedge clk);
      if (flush_mid && cyc > 0) flush = 1'b1;
      bus_grnt_ = (req_low > gdel) ? 1'b0 : 1'b1;
      bus_rdy_ = 1'b1;
      #1;
      if (!bus_as_) begin
        as_low++; as_seen = 1'b1;
        cap_addr = bus_addr; cap_rw = bus_rw; cap_be = bus_be; cap_wd = bus_wr_data;
      end
      if (as_seen) begin
        bus_rdy_ = (acc_cyc >= rdel) ? 1'b0 : 1'b1;
        acc_cyc++;
      end
      #1;
      if (cyc == 0) begin
        checks++;
        if (miss_align !== 1'b0) begin
          errors++; $display("FAIL %s miss_align got %b exp 0", name, miss_align);
        end
      end
      if (busy) busy_n++;
      else done = 1'b1;
      if (!bus_req_) req_low++;
      cyc++;
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s timeout busy still high after %0d cycles", name, cyc);
      recover();
    end else begin
      checks++;
      if (busy_n != 2 + gdel + rdel) begin
        errors++; $display("FAIL %s busy_cycles got %0d exp %0d", name, busy_n, 2 + gdel + rdel);
      end
      checks++;
      if (out !== exp_v) begin
        errors++; $display("FAIL %s out got %h exp %h", name, out, exp_v);
      end
      checks++;
      if (bus_req_ !== 1'b1) begin
        errors++; $display("FAIL %s bus_req_release got %b exp 1", name, bus_req_);
      end
      checks++;
      if (as_low != 1) begin
        errors++; $display("FAIL %s as_low_cycles got %0d exp 1", name, as_low);
      end
      checks++;
      if (cap_addr !== addr[31:2] || cap_rw !== !op_store(op) || cap_be !== exp_be) begin
        errors++;
        $display("FAIL %s addr_phase got addr=%h rw=%b be=%b exp addr=%h rw=%b be=%b",
                 name, cap_addr, cap_rw, cap_be, addr[31:2], !op_store(op), exp_be);
      end
      if (op_store(op)) begin
        checks++;
        if (cap_wd !== exp_wd) begin
          errors++; $display("FAIL %s bus_wr_data got %h exp %h", name, cap_wd, exp_wd);
        end
      end
      if (stall_n > 0) begin
        for (int i = 0; i < stall_n; i++) begin
          @(negedge clk);
          ex_out = addr ^ 32'hFFFF_0000;
          #1;
          checks++;
          if (dut.state !== STALL || busy !== 1'b0 || out !== exp_v) begin
            errors++;
            $display("FAIL %s stall_hold state=%0d busy=%b out=%h exp STALL busy=0 out=%h",
                     name, dut.state, busy, out, exp_v);
          end
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        checks++;
        if (out !== exp_v) begin
          errors++; $display("FAIL %s stall_release out got %h exp %h", name, out, exp_v);
        end
      end
      @(negedge clk);
      en = 1'b0; flush = 1'b0; stall = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
      #1;
      checks++;
      if (dut.state !== IDLE || busy !== 1'b0 || out !== ex_out) begin
        errors++;
        $display("FAIL %s back_idle state=%0d busy=%b out=%h exp IDLE busy=0 out=%h",
                 name, dut.state, busy, out, ex_out);
      end
    end
  endtask

  // An op that must not start a bus cycle (NOP, misaligned, flushed).
  task automatic no_bus_op(input logic [3:0] op, input logic [31:0] addr, input bit fl,
                           input bit exp_mis, input string name);
    @(negedge clk);
    en = 1'b1; mem_op = op; ex_out = addr; flush = fl; bus_grnt_ = 1'b0; bus_rdy_ = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (miss_align !== exp_mis || busy !== 1'b0 || bus_req_ !== 1'b1 ||
          bus_as_ !== 1'b1 || out !== addr) begin
        errors++;
        $display("FAIL %s no_bus mis=%b busy=%b req_=%b as_=%b out=%h exp mis=%b busy=0 req_=1 as_=1 out=%h",
                 name, miss_align, busy, bus_req_, bus_as_, out, exp_mis, addr);
      end
    end
    @(negedge clk);
    en = 1'b0; flush = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; en = 1'b1; mem_op = LDW; ex_out = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1 || bus_rw !== 1'b1 || bus_addr !== 30'd0 ||
        bus_be !== 4'b0000 || bus_wr_data !== 32'd0 || busy !== 1'b0 || out !== 32'h1234_5678) begin
      errors++;
      $display("FAIL reset got req_=%b as_=%b rw=%b addr=%h be=%b wd=%h busy=%b out=%h",
               bus_req_, bus_as_, bus_rw, bus_addr, bus_be, bus_wr_data, busy, out);
    end
    @(negedge clk);
    en = 1'b0; rst = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    int n = 0;
    @(negedge clk);
    en = 1'b1; mem_op = LDW; ex_out = 32'h0000_0200; bus_grnt_ = 1'b0; bus_rdy_ = 1'b1;
    #1;
    while (bus_as_ !== 1'b0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (bus_as_ !== 1'b0) begin
      errors++; $display("FAIL reset_mid never reached ACCESS as_=%b", bus_as_);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1 || busy !== 1'b0 || bus_addr !== 30'd0 ||
        bus_rw !== 1'b1 || out !== ex_out) begin
      errors++;
      $display("FAIL reset_mid got req_=%b as_=%b busy=%b addr=%h rw=%b out=%h exp 1 1 0 0 1 %h",
               bus_req_, bus_as_, busy, bus_addr, bus_rw, out, ex_out);
    end
    @(negedge clk);
    rst = 1'b1; en = 1'b0; bus_grnt_ = 1'b1;
  endtask

  task automatic test_word();
    do_op(LDW, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 1'b0,
          32'hDEAD_BEEF, 4'b1111, 32'h0, "ldw_0x100");
    do_op(STW, 32'h0000_0204, 32'hCAFE_F00D, 32'h0, 1, 2, 0, 1'b0,
          32'h0000_0204, 4'b1111, 32'hCAFE_F00D, "stw_delayed");
    no_bus_op(STW, 32'h0000_0102, 1'b0, 1'b1, "stw_misaligned");
    no_bus_op(NOP, 32'h0000_0100, 1'b0, 1'b0, "nop");
  endtask

  task automatic test_subword();
`ifdef MEM_SUBWORD_EN
    do_op(LDB, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0, 0, 0, 1'b0,
          32'hFFFF_FFF0, 4'b0001, 32'h0, "ldb_sign");
    do_op(LDBU, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0, 0, 0, 1'b0,
          32'h0000_00F0, 4'b0001, 32'h0, "ldbu_zero");
    do_op(STB, 32'h0000_0101, 32'h0000_00AB, 32'h0, 0, 0, 0, 1'b0,
          32'h0000_0101, 4'b0100, 32'hABAB_ABAB, "stb_0x101");
    do_op(LDH, 32'h0000_0002, 32'h0, 32'h1234_8001, 0, 1, 0, 1'b0,
          32'hFFFF_8001, 4'b0011, 32'h0, "ldh_low_half");
    no_bus_op(LDHU, 32'h0000_0001, 1'b0, 1'b1, "ldhu_misaligned");
`else
    no_bus_op(LDB, 32'h0000_0103, 1'b0, 1'b1, "ldb_disabled");
    no_bus_op(STB, 32'h0000_0101, 1'b0, 1'b1, "stb_disabled");
    no_bus_op(LDHU, 32'h0000_0000, 1'b0, 1'b1, "ldhu_disabled");
`endif
  endtask

  task automatic test_stall();
    do_op(LDW, 32'h0000_0300, 32'h0, 32'h5A5A_1234, 0, 0, 3, 1'b0,
          32'h5A5A_1234, 4'b1111, 32'h0, "ldw_stall3");
  endtask

  task automatic test_flush();
    no_bus_op(LDW, 32'h0000_0400, 1'b1, 1'b0, "flush_idle");
    do_op(LDW, 32'h0000_0404, 32'h0, 32'h0BAD_F00D, 1, 1, 0, 1'b1,
          32'h0BAD_F00D, 4'b1111, 32'h0, "flush_in_req");
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 8));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = (op_size(op) == 4) ? 2'b00 :
                                                 (op_size(op) == 2) ? {addr[1], 1'b0} : addr[1:0];
      wd = $urandom;
      rd = $urandom;
      if (op_size(op) == 0 || ref_misalign(op, addr)) begin
        no_bus_op(op, addr, 1'b0, ref_misalign(op, addr), "rand_nobus");
      end else begin
        do_op(op, addr, wd, rd, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)), ref_result(op, addr, rd),
              ref_be(op, addr), ref_wdata(op, wd), "rand_access");
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_word();
    test_subword();
    test_stall();
    test_flush();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_if.md
MEM_BUS_IF -- requirements
Module: mem_bus_if

Interface
REQ-001 SHALL have one clock, clk; reset rst is synchronous and active-low.
REQ-002 SHALL provide ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- en  in  1  EX/MEM entry valid
- mem_op  in  4  mem_op_e: NOP, LDW, STW, LDH, LDHU, LDB, LDBU, STH, STB
- ex_out  in  32  ALU result; byte address for memory ops
- wr_data  in  32  store data
- stall  in  1  pipeline stall
- flush  in  1  pipeline flush
- out  out  32  data to MEM register
- miss_align  out  1  misaligned access
- busy  out  1  stall request to pipeline control
- bus_req_  out  1  bus request, active-low
- bus_grnt_  in  1  bus grant, active-low
- bus_as_  out  1  address strobe, active-low
- bus_rw  out  1  1 = read, 0 = write
- bus_addr  out  30  word address, ex_out[31:2]
- bus_be  out  4  byte enables, bit 3 = byte at offset 0
- bus_wr_data  out  32  lane-steered store data
- bus_rd_data  in  32  read data
- bus_rdy_  in  1  access complete, active-low

Function
REQ-003 SHALL define access = en & mem_op != NOP & !miss_align.
REQ-004 SHALL raise miss_align combinationally when en is high and: a word op has ex_out[1:0] != 0, or a half op has ex_out[0] != 0. Misaligned ops SHALL start no bus cycle.
REQ-005 SHALL implement FSM states IDLE, REQ, ACCESS, STALL; reset state IDLE.
REQ-006 In IDLE with access & !flush: busy = 1, bus_req_ = 0, next state REQ. Otherwise busy = 0 and out = ex_out.
REQ-007 In REQ: busy = 1 and bus_req_ = 0. When bus_grnt_ = 0, register bus_as_ = 0 with bus_addr, bus_rw, bus_be, bus_wr_data, and go to ACCESS.
REQ-008 In ACCESS: bus_as_ = 1 after its single cycle.
- While bus_rdy_ = 1: busy = 1.
- On bus_rdy_ = 0: busy = 0, out = extracted bus_rd_data (ex_out for stores), release bus_req_, register that result, and go to STALL if stall = 1, else IDLE.
REQ-009 In STALL: busy = 0, out = registered result. Return to IDLE when stall = 0.
REQ-010 SHALL ignore flush outside IDLE; a started bus cycle always completes.
REQ-011 Minimum load latency: busy high for 2 cycles when grant and ready are immediate.
REQ-012 Byte order SHALL be big-endian: offset 0 = bits 31:24.
- Loads: selected lane, sign- or zero-extended to 32 bits.
- Stores: byte/half replicated across lanes, with bus_be selecting the target lane.

Reset
REQ-013 With rst = 0 at a clk edge (including mid-access): state IDLE, bus_req_ = 1, bus_as_ = 1, bus_rw = 1, bus_addr = 0, bus_be = 0, bus_wr_data = 0, result register = 0. Outputs out = ex_out and busy = 0 follow from IDLE.

Configuration
REQ-014 MEM_SUBWORD_EN defined: half and byte ops are supported per REQ-004 and REQ-012.
REQ-015 MEM_SUBWORD_EN undefined: the lane logic is omitted and LDH, LDHU, LDB, LDBU, STH, STB with en = 1 raise miss_align with no bus cycle. Word ops are unchanged and bus_be = 4'b1111.

Structure
REQ-016 mem_op_e and the FSM state enum SHALL live in shared package mem_pkg.
REQ-017 Lane steering and extension SHALL be a combinational sub-module, mem_align.

Verification
REQ-018 LDW at 0x100, grant and ready immediate, bus_rd_data = 0xDEADBEEF -> bus_addr = 0x40, busy high 2 cycles, out = 0xDEADBEEF.
REQ-019 STW at 0x102 -> miss_align = 1, no bus_req_, busy = 0.
REQ-020 LDB at 0x103 with bus_rd_data = 0x000000F0 -> out = 0xFFFFFFF0; LDBU -> out = 0x000000F0.
REQ-021 STB 0xAB at 0x101 -> bus_be = 4'b0100, bus_wr_data = 0xABABABAB, bus_rw = 0.
REQ-022 LDW with stall held 3 cycles after ready -> state STALL, out stays at the captured data, then IDLE.
REQ-023 Cases:
- Flush asserted in REQ -> access completes.
- rst = 0 in ACCESS -> bus_req_ and bus_as_ = 1 next cycle.
